// File: rtl/code_loader_if.sv
// Byte-stream input and code-memory write port of the boot-time code loader.
// Stream handshake: a byte moves on a rising CLK edge where in_valid && in_ready are both high;
// in_data/in_last matter only while in_valid is high, and in_ready never depends on in_valid.
interface code_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   // master: byte source / memory observer; slave: the loader itself
   modport master (output in_valid, in_data, in_last,
                   input  in_ready, mem_we, mem_addr, mem_wdata);
   modport slave  (input  in_valid, in_data, in_last,
                   output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/code_loader.sv
// Boot loader: packs a byte stream into 32-bit words, writes them to code memory, holds the CPU in reset.
// Optional CODE_LOADER_CHECKSUM_EN adds a running mod-2^32 sum of written words on port checksum.
module code_loader #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          MAX_WORDS  = 256,
   parameter bit          BIG_ENDIAN = 1'b1,
   localparam int         WC_W       = $clog2(MAX_WORDS) + 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            start,
   code_loader_if.slave    bus,
   output logic            cpu_reset,
   output logic            done,
   output logic            error,
   output logic [WC_W-1:0] word_count,
`ifdef CODE_LOADER_CHECKSUM_EN
   output logic [31:0]     checksum,
`endif
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {S_LOAD = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       asm_q, asm_d;
   logic              last_q, last_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [WC_W-1:0]   word_count_q, word_count_d;
`ifdef CODE_LOADER_CHECKSUM_EN
   logic [31:0]       checksum_q, checksum_d;
`endif

   logic              accept;
   logic              word_end;
   logic [4:0]        lane_shift;
   logic [31:0]       asm_next;
   logic [WC_W-1:0]   word_inc;
   logic              image_full;

   assign bus.in_ready = (state_q == S_LOAD) && !RESET;
   assign accept       = bus.in_valid && bus.in_ready;
   assign word_end     = accept && ((byte_cnt_q == 2'd3) || bus.in_last);
   // Big-endian puts byte k at bits [31-8k -: 8]; ~k equals 3-k for a 2-bit count.
   assign lane_shift   = BIG_ENDIAN ? {~byte_cnt_q, 3'b000} : {byte_cnt_q, 3'b000};
   assign asm_next     = asm_q | ({24'h0, bus.in_data} << lane_shift);
   // word_count doubles as the write index: both advance and clear together.
   assign word_inc     = word_count_q + 1'b1;
   assign image_full   = (word_inc == WC_W'(MAX_WORDS));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_LOAD;
         byte_cnt_q   <= 2'd0;
         asm_q        <= 32'h0;
         last_q       <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= BASE_ADDR;
         mem_wdata_q  <= 32'h0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         word_count_q <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
         checksum_q   <= 32'h0;
`endif
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         last_q       <= last_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
         word_count_q <= word_count_d;
`ifdef CODE_LOADER_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:  if (word_end) state_d = S_WRITE;
         S_WRITE: state_d = (last_q || image_full) ? S_DONE : S_LOAD;
         S_DONE:  if (start) state_d = S_LOAD;
         default: state_d = S_LOAD;
      endcase
   end

   always_comb begin
      byte_cnt_d   = byte_cnt_q;
      asm_d        = asm_q;
      last_d       = last_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_reset_d  = cpu_reset_q;
      done_d       = done_q;
      error_d      = error_q;
      word_count_d = word_count_q;
`ifdef CODE_LOADER_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif
      case (state_q)
         S_LOAD: begin
            if (accept) begin
               asm_d      = asm_next;
               byte_cnt_d = byte_cnt_q + 2'd1;
               last_d     = bus.in_last;
            end
            // The strobe is registered, so it is high exactly during the WRITE cycle.
            if (word_end) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = BASE_ADDR + (32'(word_count_q) << 2);
               mem_wdata_d = asm_next;
            end
         end
         S_WRITE: begin
            word_count_d = word_inc;
            byte_cnt_d   = 2'd0;
            asm_d        = 32'h0;
            last_d       = 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
            checksum_d   = checksum_q + mem_wdata_q;
`endif
            if (last_q) begin
               done_d      = 1'b1;
               error_d     = 1'b0;
               cpu_reset_d = 1'b0;
            end else if (image_full) begin
               done_d      = 1'b1;
               error_d     = 1'b1;
            end
         end
         S_DONE: begin
            if (start) begin
               cpu_reset_d  = 1'b1;
               done_d       = 1'b0;
               error_d      = 1'b0;
               word_count_d = '0;
`ifdef CODE_LOADER_CHECKSUM_EN
               checksum_d   = 32'h0;
`endif
            end
         end
         default: ;
      endcase
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_reset     = cpu_reset_q;
   assign done          = done_q;
   assign error         = error_q;
   assign word_count    = word_count_q;
`ifdef CODE_LOADER_CHECKSUM_EN
   assign checksum      = checksum_q;
`endif
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: instance a (defaults) and instance b (little-endian, base 0x100, 2 words),
// randomized byte streams checked against a byte-list model and an expected-write queue per instance.
module tb_code_loader;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RESET;
   logic [1:0]  start_v;
   logic [1:0]  vld_v;
   logic [1:0]  lst_v;
   logic [7:0]  dat_v [2];

   code_loader_if bus_a ();
   code_loader_if bus_b ();

   assign bus_a.in_valid = vld_v[0];
   assign bus_a.in_data  = dat_v[0];
   assign bus_a.in_last  = lst_v[0];
   assign bus_b.in_valid = vld_v[1];
   assign bus_b.in_data  = dat_v[1];
   assign bus_b.in_last  = lst_v[1];

   wire [1:0]  cpurst_v, done_v, err_v;
   wire [8:0]  wc_a;
   wire [1:0]  wc_b;
   wire [1:0]  st_a, st_b;
   wire [31:0] cks_v [2];
`ifdef CODE_LOADER_CHECKSUM_EN
   wire [31:0] cks_a, cks_b;
   assign cks_v[0] = cks_a;
   assign cks_v[1] = cks_b;
`else
   assign cks_v[0] = 32'h0;
   assign cks_v[1] = 32'h0;
`endif

   code_loader dut_a (
      .CLK(CLK), .RESET(RESET), .start(start_v[0]), .bus(bus_a),
      .cpu_reset(cpurst_v[0]), .done(done_v[0]), .error(err_v[0]), .word_count(wc_a),
`ifdef CODE_LOADER_CHECKSUM_EN
      .checksum(cks_a),
`endif
      .dbg_state(st_a)
   );

   code_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(2), .BIG_ENDIAN(1'b0)) dut_b (
      .CLK(CLK), .RESET(RESET), .start(start_v[1]), .bus(bus_b),
      .cpu_reset(cpurst_v[1]), .done(done_v[1]), .error(err_v[1]), .word_count(wc_b),
`ifdef CODE_LOADER_CHECKSUM_EN
      .checksum(cks_b),
`endif
      .dbg_state(st_b)
   );

   wire [1:0]  rdy_v = {bus_b.in_ready, bus_a.in_ready};
   wire [1:0]  we_v  = {bus_b.mem_we, bus_a.mem_we};
   wire [31:0] addr_v  [2];
   wire [31:0] wdata_v [2];
   wire [31:0] wc_v    [2];
   assign addr_v[0]  = bus_a.mem_addr;
   assign addr_v[1]  = bus_b.mem_addr;
   assign wdata_v[0] = bus_a.mem_wdata;
   assign wdata_v[1] = bus_b.mem_wdata;
   assign wc_v[0]    = 32'(wc_a);
   assign wc_v[1]    = 32'(wc_b);

   // instance configuration as seen by the model
   logic [31:0] base_p [2];
   int          maxw_p [2];
   bit          be_p   [2];

   // reference model: bytes of the word being assembled, words written, outcome
   logic [7:0]  m_buf  [2][4];
   int          m_n    [2];
   int          m_words[2];
   bit          m_done [2];
   bit          m_err  [2];
   logic [31:0] m_sum  [2];

   logic [63:0] exp_q_a [$];
   logic [63:0] exp_q_b [$];
   logic [63:0] hold_v  [2];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input int s, input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s.%s: observed 0x%0h required 0x%0h", (s == 0) ? "a" : "b", tag, obs, exp);
      end
   endtask

   function automatic void sb_push(input int s, input logic [63:0] v);
      if (s == 0) exp_q_a.push_back(v);
      else        exp_q_b.push_back(v);
   endfunction

   function automatic int sb_size(input int s);
      return (s == 0) ? exp_q_a.size() : exp_q_b.size();
   endfunction

   function automatic logic [63:0] sb_pop(input int s);
      if (s == 0) return exp_q_a.pop_front();
      return exp_q_b.pop_front();
   endfunction

   function automatic void model_clear(input int s);
      m_n[s] = 0; m_words[s] = 0; m_done[s] = 1'b0; m_err[s] = 1'b0; m_sum[s] = 32'h0;
   endfunction

   function automatic void model_accept(input int s, input logic [7:0] d, input logic l);
      logic [31:0] w;
      m_buf[s][m_n[s]] = d;
      m_n[s]++;
      if (m_n[s] == 4 || l) begin
         w = 32'h0;
         for (int i = 0; i < m_n[s]; i++)
            w |= 32'(m_buf[s][i]) << (be_p[s] ? (24 - 8 * i) : (8 * i));
         sb_push(s, {base_p[s] + 32'(4 * m_words[s]), w});
         m_sum[s] += w;
         m_words[s]++;
         m_n[s] = 0;
         if (l) begin
            m_done[s] = 1'b1; m_err[s] = 1'b0;
         end else if (m_words[s] == maxw_p[s]) begin
            m_done[s] = 1'b1; m_err[s] = 1'b1;
         end
      end
   endfunction

   // write monitor: every strobe must match the next expected write; otherwise addr/data hold
   always @(negedge CLK) begin
      for (int s = 0; s < 2; s++) begin
         if (RESET) begin
            hold_v[s] <= {base_p[s], 32'h0};
         end else if (we_v[s]) begin
            chk(s, "ready_in_write", 64'(rdy_v[s]), 64'd0);
            if (sb_size(s) == 0) chk(s, "spurious_write", {addr_v[s], wdata_v[s]}, 64'hffff_ffff_ffff_ffff);
            else                 chk(s, "write", {addr_v[s], wdata_v[s]}, sb_pop(s));
            hold_v[s] <= {addr_v[s], wdata_v[s]};
         end else begin
            chk(s, "hold", {addr_v[s], wdata_v[s]}, hold_v[s]);
         end
      end
   end

   // Called at a negedge; returns at a negedge with in_valid low.
   task automatic send_byte(input int s, input logic [7:0] d, input logic l, input int max_wait);
      bit acc = 1'b0;
      bit exp_acc = !m_done[s];
      vld_v[s] = 1'b1; dat_v[s] = d; lst_v[s] = l;
      for (int k = 0; k < max_wait && !acc; k++) begin
         if (rdy_v[s]) begin
            acc = 1'b1;
            model_accept(s, d, l);
         end
         @(negedge CLK);
      end
      vld_v[s] = 1'b0; lst_v[s] = 1'b0;
      chk(s, "byte_accepted", 64'(acc), 64'(exp_acc));
   endtask

   task automatic check_status(input int s);
      if (m_done[s])
         for (int k = 0; k < 20 && !done_v[s]; k++) @(negedge CLK);
      chk(s, "done", 64'(done_v[s]), 64'(m_done[s]));
      chk(s, "error", 64'(err_v[s]), 64'(m_err[s]));
      chk(s, "cpu_reset", 64'(cpurst_v[s]), 64'(!(m_done[s] && !m_err[s])));
      chk(s, "word_count", 64'(wc_v[s]), 64'(m_words[s]));
      chk(s, "in_ready", 64'(rdy_v[s]), 64'(!m_done[s]));
      chk(s, "writes_pending", 64'(sb_size(s)), 64'd0);
`ifdef CODE_LOADER_CHECKSUM_EN
      chk(s, "checksum", 64'(cks_v[s]), 64'(m_sum[s]));
`endif
   endtask

   task automatic do_reset(input bit with_start);
      RESET = 1'b1;
      start_v = {with_start, with_start};
      @(negedge CLK);
      start_v = 2'b00;
      @(negedge CLK);
      chk(0, "ready_in_reset", 64'(rdy_v[0]), 64'd0);
      RESET = 1'b0;
      model_clear(0);
      model_clear(1);
      @(negedge CLK);
      for (int s = 0; s < 2; s++) begin
         chk(s, "reset_we", 64'(we_v[s]), 64'd0);
         chk(s, "reset_addr", 64'(addr_v[s]), 64'(base_p[s]));
         chk(s, "reset_wdata", 64'(wdata_v[s]), 64'd0);
         check_status(s);
      end
   endtask

   task automatic pulse_start(input int s);
      start_v[s] = 1'b1;
      @(negedge CLK);
      start_v[s] = 1'b0;
      model_clear(s);
      @(negedge CLK);
      check_status(s);
   endtask

   task automatic send_image(input int s, input logic [7:0] bytes [], input bit with_last, input int max_gap);
      for (int i = 0; i < bytes.size(); i++) begin
         send_byte(s, bytes[i], with_last && (i == bytes.size() - 1), 8);
         repeat ($urandom_range(0, max_gap)) @(negedge CLK);
      end
   endtask

   initial begin
      logic [7:0] img [];
      int len;
      base_p[0] = 32'h0;   maxw_p[0] = 256; be_p[0] = 1'b1;
      base_p[1] = 32'h100; maxw_p[1] = 2;   be_p[1] = 1'b0;
      RESET = 1'b1; start_v = 2'b00; vld_v = 2'b00; lst_v = 2'b00;
      dat_v[0] = 8'h0; dat_v[1] = 8'h0;
      model_clear(0);
      model_clear(1);

      do_reset(1'b0);

      // back-to-back stream, two full words, last on byte 8
      img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
      send_image(0, img, 1'b1, 0);
      check_status(0);

      // partial final word
      pulse_start(0);
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      send_image(0, img, 1'b1, 2);
      check_status(0);

      // little-endian packing at base 0x100
      img = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_image(1, img, 1'b1, 1);
      check_status(1);

      // in_last on the byte that fills the last word is a success
      pulse_start(1);
      img = new[8];
      foreach (img[i]) img[i] = 8'($urandom);
      send_image(1, img, 1'b1, 1);
      check_status(1);

      // overflow: 12 bytes without in_last; bytes 9-12 must be refused
      pulse_start(1);
      for (int i = 0; i < 12; i++) send_byte(1, 8'($urandom), 1'b0, (i < 8) ? 8 : 3);
      check_status(1);

      // random images with in_valid dropping every other cycle
      for (int n = 0; n < 3; n++) begin
         pulse_start(0);
         len = $urandom_range(1, 24);
         img = new[len];
         foreach (img[i]) img[i] = 8'($urandom);
         for (int i = 0; i < len; i++) begin
            send_byte(0, img[i], i == len - 1, 8);
            @(negedge CLK);
         end
         check_status(0);
      end

      // reset after two bytes abandons the partial word
      pulse_start(0);
      send_byte(0, 8'h5A, 1'b0, 8);
      send_byte(0, 8'hA5, 1'b0, 8);
      do_reset(1'b0);
      repeat (4) @(negedge CLK);
      check_status(0);

      // restart and running sum
      img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
      send_image(0, img, 1'b1, 1);
      check_status(0);
      pulse_start(0);
      img = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_image(0, img, 1'b1, 1);
      check_status(0);

      // reset together with start from DONE: reset wins
      do_reset(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, required completion before 500000");
      $fatal(1, "watchdog");
   end

endmodule
